// File: rtl/trit_pkg.sv
// Shared ternary digit constants, FSM states and helpers.
// Used by trit_word_sequencer and other mixed-radix blocks.
package trit_pkg;

  localparam logic [1:0] TRIT_LOW  = 2'b01;
  localparam logic [1:0] TRIT_MID  = 2'b11;
  localparam logic [1:0] TRIT_HIGH = 2'b10;
  localparam logic [1:0] TRIT_ILL  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit value of a 2-bit trit pair; the illegal code reads as 0.
  function automatic logic [1:0] trit_value(input logic [1:0] t);
    logic [1:0] v;
    unique case (t)
      TRIT_LOW:  v = 2'd0;
      TRIT_MID:  v = 2'd1;
      TRIT_HIGH: v = 2'd2;
      TRIT_ILL:  v = 2'd0;
      default:   v = 2'd0;
    endcase
    return v;
  endfunction

  // Bits needed to hold 3^n - 1.
  function automatic int pow3_width(input int n);
    longint unsigned p;
    int w;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd3;
    p = p - 64'd1;
    w = 0;
    for (int i = 0; i < 64; i++)
      if ((p >> i) != 64'd0) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/trit_word_sequencer_decode.sv
// Combinational trit decoder: pair -> value plus illegal flag.
// Shared digit path; reused across mixed-radix blocks.
module trit_decode
  import trit_pkg::*;
(
  input  logic [1:0] trit_i,
  output logic [1:0] value_o,
  output logic       ill_o
);

  // Pure lookup, no state.
  always_comb begin
    value_o = trit_value(trit_i);
    ill_o   = (trit_i == TRIT_ILL);
  end

endmodule

// File: rtl/trit_word_sequencer.sv
// Sequenced ternary->binary word converter, MSB-first acc=acc*3+d.
// Optional trit_err output under `TRIT_ILLEGAL_CHECK_EN.
module trit_word_sequencer
  import trit_pkg::*;
#(
  parameter int NTRITS = 4,
  parameter int OUT_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*NTRITS-1:0] in_trits,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_bin,
  output logic                busy
`ifdef TRIT_ILLEGAL_CHECK_EN
  ,
  output logic                trit_err
`endif
);

  localparam int IDX_W = (NTRITS > 1) ? $clog2(NTRITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NTRITS - 1);

  if (NTRITS < 1) begin : g_bad_n
    $error("NTRITS must be at least 1");
  end
  if (OUT_W < pow3_width(NTRITS)) begin : g_bad_w
    $error("OUT_W too narrow for 3^NTRITS-1");
  end

  state_e              state_q, state_d;
  logic [2*NTRITS-1:0] sh_q, sh_d;
  logic [OUT_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          dig_raw;
  logic [1:0]          dig_val;
  logic                dig_ill;

`ifdef TRIT_ILLEGAL_CHECK_EN
  logic err_q, err_d;
`else
  logic unused_ill;
  assign unused_ill = dig_ill;
`endif

  assign dig_raw = 2'(sh_q >> (2 * idx_q));

  trit_decode u_dec (
    .trit_i  (dig_raw),
    .value_o (dig_val),
    .ill_o   (dig_ill)
  );

  assign out_bin = acc_q;
  assign busy    = (state_q != IDLE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
`ifdef TRIT_ILLEGAL_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
`ifdef TRIT_ILLEGAL_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state, accumulate step and handshake outputs.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef TRIT_ILLEGAL_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_d    = in_trits;
          acc_d   = '0;
          idx_d   = IDX_TOP;
          state_d = CONV;
`ifdef TRIT_ILLEGAL_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      CONV: begin
        acc_d = (acc_q << 1) + acc_q + OUT_W'(dig_val);
`ifdef TRIT_ILLEGAL_CHECK_EN
        err_d = err_q | dig_ill;
`endif
        if (idx_q == '0) state_d = DONE;
        else idx_d = idx_q - 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
`ifdef TRIT_ILLEGAL_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TRIT_ILLEGAL_CHECK_EN
  assign trit_err = err_q;
`endif

endmodule

// File: tb/tb_trit_word_sequencer.sv
// Directed bench for trit_word_sequencer with a result scoreboard.
// Optional trit_err checks under `TRIT_ILLEGAL_CHECK_EN.
module tb_trit_word_sequencer;

  localparam int N = 4;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2*N-1:0] in_trits;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
  logic         busy;
`ifdef TRIT_ILLEGAL_CHECK_EN
  logic         trit_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sb_bin[$];
  int sb_err[$];
  int out_times[$];

  trit_word_sequencer #(.NTRITS(N), .OUT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_trits  (in_trits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .busy      (busy)
`ifdef TRIT_ILLEGAL_CHECK_EN
    ,
    .trit_err  (trit_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_bin(input logic [2*N-1:0] w);
    int acc;
    logic [1:0] t;
    acc = 0;
    for (int i = N - 1; i >= 0; i--) begin
      t = w[2*i +: 2];
      acc = acc * 3 + ((t == 2'b11) ? 1 : (t == 2'b10) ? 2 : 0);
    end
    return acc;
  endfunction

  function automatic int model_err(input logic [2*N-1:0] w);
    int e;
    e = 0;
    for (int i = 0; i < N; i++)
      if (w[2*i +: 2] == 2'b00) e = 1;
    return e;
  endfunction

  // Scoreboard: push on capture, pop and compare on acceptance.
  always @(negedge clk) begin
    int e_bin;
    int e_err;
    if (rst) begin
      sb_bin.delete();
      sb_err.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", int'(sb_bin.size() != 0), 1);
        if (sb_bin.size() != 0) begin
          e_bin = sb_bin.pop_front();
          e_err = sb_err.pop_front();
          chk("out_bin", int'(out_bin), e_bin);
`ifdef TRIT_ILLEGAL_CHECK_EN
          chk("trit_err", int'(trit_err), e_err);
`endif
          out_times.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        sb_bin.push_back(model_bin(in_trits));
        sb_err.push_back(model_err(in_trits));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step(1);
      n++;
    end
  endtask

  task automatic run_word(input logic [2*N-1:0] w);
    int n;
    in_trits = w;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("busy_cap", int'(busy), 1);
    chk("in_ready_conv", int'(in_ready), 0);
    wait_valid(n);
    chk("latency", n, N);
    step(1);
    chk("in_ready_back", int'(in_ready), 1);
    chk("out_valid_clr", int'(out_valid), 0);
`ifdef TRIT_ILLEGAL_CHECK_EN
    chk("err_clr", int'(trit_err), 0);
`endif
  endtask

  localparam logic [2*N-1:0] W_A    = 8'b10_11_01_10;
  localparam logic [2*N-1:0] W_LOW  = 8'b01_01_01_01;
  localparam logic [2*N-1:0] W_HIGH = 8'b10_10_10_10;
  localparam logic [2*N-1:0] W_FOUR = 8'b01_01_11_11;
  localparam logic [2*N-1:0] W_ILL  = 8'b00_01_01_10;

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_trits = '0;
    step(2);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bin", int'(out_bin), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    out_ready = 1'b1;
    run_word(W_A);
    run_word(W_LOW);
    run_word(W_HIGH);

    out_ready = 1'b0;
    in_trits = W_A;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_latency", n, N);
    in_trits = W_LOW;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_bin", int'(out_bin), 65);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step(1);
    chk("bp_idle_ready", int'(in_ready), 1);
    chk("bp_idle_busy", int'(busy), 0);
    step(1);
    chk("bp_capture", int'(busy), 1);
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_next_bin", int'(out_bin), 0);
    step(1);

    in_trits = W_A;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_bin", int'(out_bin), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    run_word(W_FOUR);

    in_trits = W_ILL;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_valid(n);
    chk("ill_bin", int'(out_bin), 2);
`ifdef TRIT_ILLEGAL_CHECK_EN
    chk("ill_flag", int'(trit_err), 1);
`endif
    step(1);
`ifdef TRIT_ILLEGAL_CHECK_EN
    chk("ill_flag_clr", int'(trit_err), 0);
`endif
    run_word(W_LOW);

    out_times.delete();
    in_trits = W_A;
    in_valid = 1'b1;
    step(1);
    in_trits = W_LOW;
    n = 0;
    while (!in_ready && n < 40) begin step(1); n++; end
    chk("b2b_gap1", n, N + 1);
    step(1);
    in_trits = W_HIGH;
    n = 0;
    while (!in_ready && n < 40) begin step(1); n++; end
    chk("b2b_gap2", n, N + 1);
    step(1);
    in_valid = 1'b0;
    wait_valid(n);
    step(2);
    chk("b2b_count", out_times.size(), 3);
    if (out_times.size() == 3) begin
      chk("b2b_space1", out_times[1] - out_times[0], N + 2);
      chk("b2b_space2", out_times[2] - out_times[1], N + 2);
    end
    chk("sb_drained", sb_bin.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
